// File: rtl/lane_accumulator_if.sv
// rtl/lane_accumulator_if.sv - op, external-read and sweep-control signals of lane_accumulator
interface lane_accumulator_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_op;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  clr_all;
    logic                  busy;

    modport master (
        output in_valid, in_op, in_addr, in_data, rd_en, rd_addr, clr_all,
        input  in_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  in_valid, in_op, in_addr, in_data, rd_en, rd_addr, clr_all,
        output in_ready, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/lane_accumulator.sv
// rtl/lane_accumulator.sv - SIMD lane accumulator memory with forwarded 4-stage RMW pipeline and zero sweep
module lane_accumulator #(
    parameter int ADDR_WIDTH = 9,
    parameter int LANES      = 4,
    parameter int LANE_W     = 16,
    parameter int LOGQ       = 16
) (
    input  logic              clk,
    input  logic              rstn,
    lane_accumulator_if.slave bus
);
    localparam int DEPTH      = 2 ** ADDR_WIDTH;
    localparam int DATA_WIDTH = LANES * LANE_W;
    localparam logic [LANE_W-1:0] LANE_MASK = {LANE_W{1'b1}} >> (LANE_W - LOGQ);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] { OP_WRITE = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_ZERO = 2'b11 } op_t;
    typedef enum logic [1:0] { IDLE, DRAIN, SWEEP } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    logic                  in_ready_q;
    logic                  busy_q;
    logic [ADDR_WIDTH-1:0] sweep_addr;

    logic                  s1_valid, s2_valid, s3_valid, s4_valid;
    op_t                   s1_op, s2_op;
    logic [ADDR_WIDTH-1:0] s1_addr, s2_addr, s3_addr, s4_addr;
    logic [DATA_WIDTH-1:0] s1_data, s2_data, s3_data, s4_data;
    logic [DATA_WIDTH-1:0] rmw_q;
    logic [DATA_WIDTH-1:0] old_word, alu_result;

    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    logic accept;
    logic pipe_empty;

    assign accept       = bus.in_valid && in_ready_q;
    assign pipe_empty   = !s1_valid && !s2_valid && !s3_valid;
    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

    // The sweep owns the single write port; the pipeline is empty while it runs.
    assign wr_en   = (state == SWEEP) || s3_valid;
    assign wr_addr = (state == SWEEP) ? sweep_addr : s3_addr;
    assign wr_data = (state == SWEEP) ? '0 : s3_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            sweep_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.clr_all) begin
                        state      <= DRAIN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end else begin
                        in_ready_q <= 1'b1;
                        busy_q     <= accept || s1_valid || s2_valid;
                    end
                end
                DRAIN: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                    if (pipe_empty) begin
                        state      <= SWEEP;
                        sweep_addr <= '0;
                    end
                end
                SWEEP: begin
                    if (sweep_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s4_valid <= 1'b0;
            s1_op    <= OP_WRITE;
            s2_op    <= OP_WRITE;
            s1_addr  <= '0;
            s2_addr  <= '0;
            s3_addr  <= '0;
            s4_addr  <= '0;
            s1_data  <= '0;
            s2_data  <= '0;
            s3_data  <= '0;
            s4_data  <= '0;
        end else begin
            s1_valid <= accept;
            s1_op    <= op_t'(bus.in_op);
            s1_addr  <= bus.in_addr;
            s1_data  <= bus.in_data;
            s2_valid <= s1_valid;
            s2_op    <= s1_op;
            s2_addr  <= s1_addr;
            s2_data  <= s1_data;
            s3_valid <= s2_valid;
            s3_addr  <= s2_addr;
            s3_data  <= alu_result;
            // s4 keeps the word written on the same edge as the s1 read, which that read cannot see.
            s4_valid <= s3_valid;
            s4_addr  <= s3_addr;
            s4_data  <= s3_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rmw_q <= mem[s1_addr];
    end

    always_comb begin
        old_word = rmw_q;
        if (s4_valid && (s4_addr == s2_addr)) old_word = s4_data;
        if (s3_valid && (s3_addr == s2_addr)) old_word = s3_data;
    end

    always_comb begin : lane_alu
        logic [LANE_W-1:0] a, b, r;
        alu_result = '0;
        for (int i = 0; i < LANES; i++) begin
            a = old_word[i*LANE_W +: LANE_W];
            b = s2_data[i*LANE_W +: LANE_W];
            case (s2_op)
                OP_WRITE: r = b;
                OP_ADD:   r = a + b;
                OP_SUB:   r = a - b;
                default:  r = '0;
            endcase
            alu_result[i*LANE_W +: LANE_W] = r & LANE_MASK;
        end
    end

    // External reads see a write landing on the same edge, never the in-flight stages.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_q <= (wr_en && (wr_addr == bus.rd_addr)) ? wr_data : mem[bus.rd_addr];
            end
        end
    end
endmodule

// File: tb/tb_lane_accumulator.sv
// tb/tb_lane_accumulator.sv - scoreboard bench for lane_accumulator at LOGQ=16 and LOGQ=15
module tb_lane_accumulator;
    localparam int AW    = 9;
    localparam int DW    = 64;
    localparam int DEPTH = 512;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    lane_accumulator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if0 ();
    lane_accumulator_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if1 ();

    lane_accumulator #(.ADDR_WIDTH(AW), .LANES(4), .LANE_W(16), .LOGQ(16)) dut0 (.clk(clk), .rstn(rstn), .bus(if0));
    lane_accumulator #(.ADDR_WIDTH(AW), .LANES(4), .LANE_W(16), .LOGQ(15)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] lval [2][DEPTH];
    logic [DW-1:0] cmem [2][DEPTH];
    logic          pv [1:3];
    logic [AW-1:0] pa [1:3];
    logic [DW-1:0] pd [2][1:3];
    logic [DW-1:0] sbq0 [$];
    logic [DW-1:0] sbq1 [$];
    logic          exp_rv;
    logic          chk_rdy;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_op(input logic [DW-1:0] old, input logic [1:0] op,
                                               input logic [DW-1:0] d, input int logq);
        logic [DW-1:0] r;
        logic [15:0] m, o, x, v;
        m = 16'((32'd1 << logq) - 1);
        r = '0;
        for (int i = 0; i < 4; i++) begin
            o = old[i*16 +: 16];
            x = d[i*16 +: 16];
            case (op)
                2'b00:   v = x;
                2'b01:   v = o + x;
                2'b10:   v = o - x;
                default: v = 16'h0;
            endcase
            r[i*16 +: 16] = v & m;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] rep(input logic [15:0] v);
        return {4{v}};
    endfunction

    task automatic tick(input logic v, input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] dt,
                        input logic re, input logic [AW-1:0] ra, input logic clr);
        logic [DW-1:0] nv;
        if (v && chk_rdy) begin
            check("in_ready0", if0.in_ready, 1);
            check("in_ready1", if1.in_ready, 1);
        end
        if0.in_valid = v;  if0.in_op = op;  if0.in_addr = a;  if0.in_data = dt;
        if0.rd_en = re;    if0.rd_addr = ra; if0.clr_all = clr;
        if1.in_valid = v;  if1.in_op = op;  if1.in_addr = a;  if1.in_data = dt;
        if1.rd_en = re;    if1.rd_addr = ra; if1.clr_all = clr;
        // op issued three cycles ago lands in memory at the end of this cycle
        if (pv[3]) for (int d = 0; d < 2; d++) cmem[d][pa[3]] = pd[d][3];
        for (int s = 3; s > 1; s--) begin
            pv[s] = pv[s-1];
            pa[s] = pa[s-1];
            for (int d = 0; d < 2; d++) pd[d][s] = pd[d][s-1];
        end
        pv[1] = v;
        pa[1] = a;
        for (int d = 0; d < 2; d++) begin
            if (v) begin
                nv = model_op(lval[d][a], op, dt, (d == 0) ? 16 : 15);
                lval[d][a] = nv;
                pd[d][1] = nv;
            end
        end
        if (re) begin
            sbq0.push_back(cmem[0][ra]);
            sbq1.push_back(cmem[1][ra]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 2'b00, '0, '0, 0, '0, 0);
    endtask

    task automatic rd(input logic [AW-1:0] ra);
        tick(0, 2'b00, '0, '0, 1, ra, 0);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((if0.busy || if1.busy) && n < limit) begin
            idle(1);
            n++;
        end
        check("wait_busy0", if0.busy, 0);
        check("wait_busy1", if1.busy, 0);
    endtask

    task automatic model_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < DEPTH; i++) begin
                lval[d][i] = '0;
                cmem[d][i] = '0;
            end
    endtask

    task automatic sb_check(input int d, input logic rv, input logic [DW-1:0] rdat);
        logic [DW-1:0] e;
        if (!rv) return;
        if (d == 0) begin
            if (sbq0.size() == 0) begin check("sb_extra0", rv, 0); return; end
            e = sbq0.pop_front();
            check("rd_data0", rdat, e);
        end else begin
            if (sbq1.size() == 0) begin check("sb_extra1", rv, 0); return; end
            e = sbq1.pop_front();
            check("rd_data1", rdat, e);
        end
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) exp_rv <= 1'b0;
        else       exp_rv <= if0.rd_en;
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("rd_valid0", if0.rd_valid, exp_rv);
            check("rd_valid1", if1.rd_valid, exp_rv);
            sb_check(0, if0.rd_valid, if0.rd_data);
            sb_check(1, if1.rd_valid, if1.rd_data);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        chk_rdy = 1'b1;
        for (int s = 1; s <= 3; s++) pv[s] = 1'b0;
        if0.in_valid = 0; if0.in_op = 0; if0.in_addr = 0; if0.in_data = 0;
        if0.rd_en = 0; if0.rd_addr = 0; if0.clr_all = 0;
        if1.in_valid = 0; if1.in_op = 0; if1.in_addr = 0; if1.in_data = 0;
        if1.rd_en = 0; if1.rd_addr = 0; if1.clr_all = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready0", if0.in_ready, 1);
        check("rst_busy0", if0.busy, 0);
        check("rst_rd_valid0", if0.rd_valid, 0);
        check("rst_rd_data0", if0.rd_data, 0);
        check("rst_in_ready1", if1.in_ready, 1);
        check("rst_busy1", if1.busy, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // initial sweep, then zero readback
        tick(0, 2'b00, '0, '0, 0, '0, 1);
        check("clr_in_ready0", if0.in_ready, 0);
        check("clr_busy0", if0.busy, 1);
        wait_idle(2000);
        model_clear();
        rd(0); rd(17); rd(9'(DEPTH - 1));
        idle(3);

        // write then add in consecutive cycles, read four cycles after the write
        tick(1, 2'b00, 5, 64'h0004_0003_0002_0001, 0, '0, 0);
        tick(1, 2'b01, 5, 64'h0028_001E_0014_000A, 0, '0, 0);
        idle(2);
        rd(5);
        idle(4);

        // eight back-to-back adds of all-ones lanes
        repeat (8) tick(1, 2'b01, 9, rep(16'hFFFF), 0, '0, 0);
        idle(3);
        rd(9); rd(10);
        idle(3);

        // modulus wrap both directions
        tick(1, 2'b00, 7, rep(16'h7FFF), 0, '0, 0);
        tick(1, 2'b01, 7, rep(16'h0001), 0, '0, 0);
        tick(1, 2'b10, 8, rep(16'h0001), 0, '0, 0);
        idle(3);
        rd(7); rd(8);
        idle(3);

        // interleaved adds two cycles apart with a read of address 3 every cycle
        for (int k = 0; k < 8; k++) begin
            tick(1, 2'b01, (k % 2) ? 9'd4 : 9'd3, {$urandom, $urandom}, 1, 3, 0);
            tick(0, 2'b00, '0, '0, 1, 3, 0);
        end
        idle(3);
        rd(3); rd(4);
        idle(3);

        // random stream over a few addresses exercising every forwarding distance
        for (int k = 0; k < 60; k++) begin
            tick(($urandom % 4) != 0, 2'($urandom), 9'($urandom_range(0, 3)), {$urandom, $urandom},
                 1, 9'($urandom_range(0, 3)), 0);
        end
        idle(3);
        rd(0); rd(1); rd(2); rd(3);
        idle(3);

        // op accepted with clr_all is wiped by the sweep
        tick(1, 2'b01, 20, rep(16'h0005), 0, '0, 1);
        check("clr_op_in_ready0", if0.in_ready, 0);
        check("clr_op_busy1", if1.busy, 1);
        wait_idle(2000);
        model_clear();
        rd(20);
        idle(3);

        // reset in the middle of a sweep
        tick(1, 2'b01, 21, rep(16'h0003), 0, '0, 1);
        idle(10);
        check("sweep_in_ready0", if0.in_ready, 0);
        check("sweep_busy0", if0.busy, 1);
        rstn = 1'b0;
        #1;
        check("abort_in_ready0", if0.in_ready, 1);
        check("abort_busy0", if0.busy, 0);
        check("abort_rd_valid0", if0.rd_valid, 0);
        check("abort_in_ready1", if1.in_ready, 1);
        check("abort_busy1", if1.busy, 0);
        for (int s = 1; s <= 3; s++) pv[s] = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        tick(1, 2'b00, 2, 64'h1234_0567_00AB_7FFF, 0, '0, 0);
        idle(3);
        rd(2);
        idle(3);

        check("sb_left0", 64'(sbq0.size()), 0);
        check("sb_left1", 64'(sbq1.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lane_accumulator.md
LANE_ACCUMULATOR -- requirements
Module: lane_accumulator

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 9, word address width; DEPTH = 2**ADDR_WIDTH.
REQ-002 SHALL have parameter LANES, default 4, number of independent SIMD lanes per word.
REQ-003 SHALL have parameter LANE_W, default 16, storage bits per lane; DATA_WIDTH = LANES*LANE_W.
REQ-004 SHALL have parameter LOGQ, default 16, modulus exponent, 1 <= LOGQ <= LANE_W; lane arithmetic is mod 2**LOGQ.
REQ-005 SHALL have port clk input 1, clock.
REQ-006 SHALL have port rstn input 1, reset, asynchronous, active-low.
REQ-007 SHALL have port in_valid input 1, operation request.
REQ-008 SHALL have port in_ready output 1, operation accepted when in_valid && in_ready.
REQ-009 SHALL have port in_op input 2, operation code: 00 WRITE, 01 ADD, 10 SUB, 11 ZERO.
REQ-010 SHALL have port in_addr input ADDR_WIDTH, target word.
REQ-011 SHALL have port in_data input DATA_WIDTH, operand, lane i = bits [i*LANE_W +: LANE_W].
REQ-012 SHALL have port rd_en input 1, external read request.
REQ-013 SHALL have port rd_addr input ADDR_WIDTH, read word.
REQ-014 SHALL have port rd_valid output 1, rd_data valid.
REQ-015 SHALL have port rd_data output DATA_WIDTH, read result.
REQ-016 SHALL have port clr_all input 1, single-cycle pulse requesting a whole-memory zero sweep.
REQ-017 SHALL have port busy output 1, high while the sweep runs or any operation is in flight.

Function
REQ-018 Storage SHALL be an internal DEPTH x DATA_WIDTH array with one write port and two synchronous read ports, one for read-modify-write (RMW) and one for external reads.
REQ-019 Per lane, results SHALL be: WRITE = operand; ADD = old + operand; SUB = old - operand; ZERO = 0. All are mod 2**LOGQ.
REQ-020 Carries SHALL NOT cross lanes, and bits [LANE_W-1:LOGQ] of every stored lane SHALL be 0.
REQ-021 Pipeline: an op accepted in cycle T SHALL issue its RMW read in T+1, perform the ALU in T+2, and write memory at the end of T+3.
REQ-022 in_ready SHALL be high whenever the FSM is in IDLE; a full-rate stream of one op per cycle SHALL be sustained.
REQ-023 Forwarding: the old value used by any op SHALL equal the result of all earlier accepted ops to the same address, including back-to-back ops and ops 1, 2 or 3 cycles apart, with the youngest match winning.
REQ-024 External read: a request in cycle T SHALL give rd_valid=1 in T+1 with rd_data = memory contents at the end of T; in-flight ops SHALL NOT be visible and reads SHALL NOT stall ops.
REQ-025 FSM states SHALL be IDLE, DRAIN and SWEEP.
REQ-026 clr_all in IDLE SHALL move to DRAIN, with in_ready low from the following cycle; an op accepted in the same cycle as clr_all is executed before the sweep.
REQ-027 DRAIN SHALL move to SWEEP when the pipeline is empty.
REQ-028 SWEEP SHALL write zero to addresses 0..DEPTH-1, one per cycle, then return to IDLE; the counter SHALL NOT wrap.
REQ-029 clr_all while in DRAIN or SWEEP SHALL be ignored.
REQ-030 External reads SHALL remain serviced during DRAIN and SWEEP.
REQ-031 busy SHALL be high in DRAIN and SWEEP, and in IDLE whenever any pipeline stage holds a valid op.
REQ-032 in_valid with in_ready low SHALL have no effect; an op is not held, and the source retries.

Reset
REQ-033 rstn low SHALL asynchronously clear all pipeline valids, forwarding entries, rd_valid and busy, set the FSM to IDLE and set in_ready=1; rd_data SHALL reset to 0.
REQ-034 Memory contents SHALL be undefined after reset; software issues clr_all.
REQ-035 Reset asserted mid-operation or mid-sweep SHALL abort all activity; a partially written memory is acceptable.

Verification
REQ-036 clr_all, wait for busy low, then read addresses 0, 17 and DEPTH-1 -> each returns 0.
REQ-037 WRITE addr 5 lanes {1,2,3,4}, then ADD addr 5 {10,20,30,40} in consecutive cycles, read addr 5 at T+4 -> {11,22,33,44}.
REQ-038 Eight back-to-back ADDs to addr 9, each with every lane = 0xFFFF, starting from 0 and with LOGQ=16 -> lanes 0xFFF8 and no carry into adjacent lanes.
REQ-039 LOGQ=15: WRITE 0x7FFF, then ADD 1 -> lane 0x0000; SUB 1 from 0 -> 0x7FFF, with bit 15 zero.
REQ-040 Interleave ADDs to addresses 3,4,3,4 with ops 2 cycles apart, plus a concurrent read of addr 3 every cycle -> final values correct; reads show only committed values, rd_valid exactly 1 cycle after rd_en.
REQ-041 clr_all asserted together with an accepted ADD, reset asserted mid-sweep -> in_ready low, busy high, the ADD is discarded by the sweep; after reset, in_ready=1, busy=0 and the FSM is in IDLE.
